// File: rtl/gpr_regfile_if.sv
// gpr_regfile_if: write-back and decode-side bus of the general-purpose register file.
//   we/waddr/wdata             write port, driven by write-back
//   re1/raddr1 -> rdata1       read port 1, driven by decode
//   re2/raddr2 -> rdata2       read port 2, driven by decode
//   init_busy                  high while the post-reset clear sweep runs
// Modports: master = pipeline side, slave = register file.
interface gpr_regfile_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              init_busy;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, init_busy
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, init_busy
  );
endinterface

// File: rtl/gpr_regfile.sv
// gpr_regfile: general-purpose register file between MEM/WB and ID.
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  gpr_regfile_if.slave: one write port, two combinational read ports
//        with same-cycle write->read bypass, init_busy status.
// Entry 0 reads as zero and is never written. After reset an optional
// sweep zeroes entries 1..NUM_REGS-1; writes during the sweep are dropped
// and reads return zero.
module gpr_regfile #(
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  gpr_regfile_if.slave    bus
);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              init_busy, init_busy_nxt;
  logic [DATA_W-1:0] mem [NUM_REGS];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        state     <= INIT;
        init_busy <= 1'b1;
      end else begin
        state     <= READY;
        init_busy <= 1'b0;
      end
      clr_ptr <= ADDR_W'(1);
    end else begin
      state     <= state_nxt;
      clr_ptr   <= clr_ptr_nxt;
      init_busy <= init_busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    clr_ptr_nxt   = clr_ptr;
    init_busy_nxt = init_busy;
    case (state)
      INIT: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST_ADDR) begin
          state_nxt     = READY;
          init_busy_nxt = 1'b0;
        end
      end
      READY: begin
        init_busy_nxt = 1'b0;
      end
      default: begin
        state_nxt = READY;
      end
    endcase
  end

  // Array update: sweep clears one entry per cycle; normal writes only in
  // READY and never to entry 0. Reset leaves the contents alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_ptr] <= '0;
      end else if (bus.we && (bus.waddr != '0)) begin
        mem[bus.waddr] <= bus.wdata;
      end
    end
  end

  // Read port 1
  always_comb begin
    bus.rdata1 = '0;
    if (rst || (state == INIT)) begin
      bus.rdata1 = '0;
    end else if (bus.raddr1 == '0) begin
      bus.rdata1 = '0;
    end else if (bus.re1 && bus.we && (bus.raddr1 == bus.waddr)) begin
      bus.rdata1 = bus.wdata;
    end else if (bus.re1) begin
      bus.rdata1 = mem[bus.raddr1];
    end
  end

  // Read port 2
  always_comb begin
    bus.rdata2 = '0;
    if (rst || (state == INIT)) begin
      bus.rdata2 = '0;
    end else if (bus.raddr2 == '0) begin
      bus.rdata2 = '0;
    end else if (bus.re2 && bus.we && (bus.raddr2 == bus.waddr)) begin
      bus.rdata2 = bus.wdata;
    end else if (bus.re2) begin
      bus.rdata2 = mem[bus.raddr2];
    end
  end

  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_gpr_regfile.sv
// tb_gpr_regfile: directed self-checking bench for gpr_regfile.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_gpr_regfile;

  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_bad;

  gpr_regfile_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  gpr_regfile #(
    .NUM_REGS      (32),
    .ADDR_W        (5),
    .DATA_W        (32),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Count cycles until init_busy drops; optionally issue one write at a
  // chosen cycle of the sweep (write_at < 0 disables it).
  task automatic wait_init(input int write_at, input logic [4:0] wa,
                           input logic [31:0] wd, output int cycles);
    cycles = 0;
    while (bus.init_busy && cycles < 100) begin
      if (cycles == write_at) begin
        bus.we = 1'b1; bus.waddr = wa; bus.wdata = wd;
        bus.re1 = 1'b1; bus.raddr1 = wa;
        settle();
        check("init_read_zero", bus.rdata1, 32'h0);
      end else begin
        bus.we = 1'b0;
      end
      tick();
      cycles++;
    end
    bus.we = 1'b0;
    bus.re1 = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
    bus.we = 1'b1; bus.waddr = wa; bus.wdata = wd;
    tick();
    bus.we = 1'b0;
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0;
    bus.re2 = 1'b0; bus.raddr2 = '0;

    // T1: reset and sweep length
    tick();
    tick();
    check("rst_busy", {31'b0, bus.init_busy}, 32'h1);
    bus.re1 = 1'b1; bus.raddr1 = 5'd4;
    settle();
    check("rst_read_zero", bus.rdata1, 32'h0);
    rst = 1'b0;
    bus.re1 = 1'b0;
    wait_init(-1, 5'd0, 32'h0, cyc);
    check("t1_busy_len", cyc, 32'd31);
    check("t1_busy_low", {31'b0, bus.init_busy}, 32'h0);
    bus.re1 = 1'b1; bus.re2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.raddr1 = 5'(i);
      bus.raddr2 = 5'(31 - i);
      settle();
      check("t1_clear_p1", bus.rdata1, 32'h0);
      check("t1_clear_p2", bus.rdata2, 32'h0);
    end
    bus.re1 = 1'b0; bus.re2 = 1'b0;

    // T2: write then read
    write_reg(5'd5, 32'hDEADBEEF);
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd6;
    settle();
    check("t2_r5", bus.rdata1, 32'hDEADBEEF);
    check("t2_r6", bus.rdata2, 32'h0);

    // T3: bypass on both ports, then stored value
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
    bus.raddr1 = 5'd7; bus.raddr2 = 5'd7;
    settle();
    check("t3_byp_p1", bus.rdata1, 32'h12345678);
    check("t3_byp_p2", bus.rdata2, 32'h12345678);
    tick();
    bus.we = 1'b0;
    settle();
    check("t3_mem_p1", bus.rdata1, 32'h12345678);
    check("t3_mem_p2", bus.rdata2, 32'h12345678);

    // Bypass on port 2 only; port 1 reads the array
    bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'hCAFE0010;
    bus.raddr1 = 5'd5; bus.raddr2 = 5'd10;
    settle();
    check("byp2_p1_mem", bus.rdata1, 32'hDEADBEEF);
    check("byp2_p2_byp", bus.rdata2, 32'hCAFE0010);
    tick();
    bus.we = 1'b0;

    // Highest address
    write_reg(5'd31, 32'h31313131);
    bus.raddr1 = 5'd31;
    settle();
    check("r31", bus.rdata1, 32'h31313131);

    // T4: writes to r0 are discarded
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    settle();
    check("t4_r0_same", bus.rdata1, 32'h0);
    tick();
    bus.we = 1'b0;
    settle();
    check("t4_r0_next", bus.rdata1, 32'h0);

    // T6: read enable gating
    write_reg(5'd9, 32'h0000FFFF);
    bus.re1 = 1'b0; bus.raddr1 = 5'd9;
    settle();
    check("t6_re_off", bus.rdata1, 32'h0);
    bus.re1 = 1'b1;
    settle();
    check("t6_re_on", bus.rdata1, 32'h0000FFFF);

    // T5: reset from READY forces zero reads, then reset mid-sweep
    bus.raddr1 = 5'd5;
    rst = 1'b1;
    settle();
    check("t5_rst_read", bus.rdata1, 32'h0);
    tick();
    rst = 1'b0;
    bus.re1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t5_busy_mid", {31'b0, bus.init_busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Write to r3 once the sweep pointer is already past it
    wait_init(20, 5'd3, 32'hA5A5A5A5, cyc);
    check("t5_busy_len", cyc, 32'd31);
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    settle();
    check("t5_r3_dropped", bus.rdata1, 32'h0);
    check("t5_r5_cleared", bus.rdata2, 32'h0);
    bus.raddr1 = 5'd9; bus.raddr2 = 5'd31;
    settle();
    check("t5_r9_cleared", bus.rdata1, 32'h0);
    check("t5_r31_cleared", bus.rdata2, 32'h0);

    // Writes work again after the second sweep
    write_reg(5'd3, 32'h0BADF00D);
    bus.raddr1 = 5'd3;
    settle();
    check("post_init_write", bus.rdata1, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
